// File: rtl/count_display_pkg.sv
// Shared types, sizes and the 7-segment lookup for the count display path.
package count_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int NUM_DIGITS = 3;
  localparam int BCD_W      = 12;

  // Active-high segment code {g,f,e,d,c,b,a}; non-decimal nibbles render dark.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    logic [6:0] code;
    case (nibble)
      4'd0:    code = 7'h3F;
      4'd1:    code = 7'h06;
      4'd2:    code = 7'h5B;
      4'd3:    code = 7'h4F;
      4'd4:    code = 7'h66;
      4'd5:    code = 7'h6D;
      4'd6:    code = 7'h7D;
      4'd7:    code = 7'h07;
      4'd8:    code = 7'h7F;
      4'd9:    code = 7'h6F;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/count_display_driver_if.sv
// Counter-to-display bus: count input side plus BCD status and display pins.
interface count_display_driver_if;
  import count_display_pkg::*;

  // value_valid is a one-cycle strobe with no ready/backpressure: the consumer
  // always accepts it, and strobes arriving during a conversion collapse into
  // a single pending slot where the latest value wins.
  logic [7:0]            value;
  logic                  value_valid;
  logic [BCD_W-1:0]      bcd;
  logic                  busy;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;

  modport master (
    output value, value_valid,
    input  bcd, busy, seg, an
  );

  modport slave (
    input  value, value_valid,
    output bcd, busy, seg, an
  );

endinterface

// File: rtl/count_display_driver_bin2bcd_seq.sv
// Sequential double-dabble converter (one shift per cycle) with a one-deep pending slot.
module bin2bcd_seq
  import count_display_pkg::*;
(
  input  logic             clkin,
  input  logic             reset,
  input  logic [7:0]       value,
  input  logic             value_valid,
  output logic [BCD_W-1:0] bcd,
  output logic             busy
);

  conv_state_t      state;
  logic [7:0]       operand;
  logic [BCD_W-1:0] scratch;
  logic [2:0]       bit_cnt;
  logic             pending;
  logic [7:0]       pend_val;
  logic [BCD_W-1:0] adjusted;

  always_comb begin
    adjusted = scratch;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) adjusted[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clkin) begin
    if (!reset) begin
      state    <= IDLE;
      operand  <= '0;
      scratch  <= '0;
      bit_cnt  <= '0;
      pending  <= 1'b0;
      pend_val <= '0;
      bcd      <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (value_valid) begin
            operand <= value;
            scratch <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Hundreds never exceeds 2, so the adjusted MSB is always zero.
          scratch <= {adjusted[BCD_W-2:0], operand[7]};
          operand <= {operand[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= DONE;
          if (value_valid) begin
            pend_val <= value;
            pending  <= 1'b1;
          end
        end
        DONE: begin
          bcd <= scratch;
          // A strobe landing on this edge is newer than pend_val, so it wins.
          if (value_valid || pending) begin
            operand <= value_valid ? value : pend_val;
            scratch <= '0;
            bit_cnt <= '0;
            pending <= 1'b0;
            state   <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/count_display_driver.sv
// Count display top: BCD conversion plus 3-digit multiplexed 7-segment drive.
module count_display_driver
  import count_display_pkg::*;
#(
  parameter int REFRESH_DIV    = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_LEADING  = 1
) (
  input logic                   clkin,
  input logic                   reset,
  count_display_driver_if.slave bus
);

  localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);
  localparam logic [6:0]  SEG_OFF      = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [BCD_W-1:0]      bcd_q;
  logic                  busy_q;
  logic [15:0]           refresh_cnt;
  logic [1:0]            digit_idx;
  logic [3:0]            nibble;
  logic                  blank;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;

  bin2bcd_seq u_conv (
    .clkin       (clkin),
    .reset       (reset),
    .value       (bus.value),
    .value_valid (bus.value_valid),
    .bcd         (bcd_q),
    .busy        (busy_q)
  );

  // Digit selection and blanking always use the registered result, never scratch.
  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    case (digit_idx)
      2'd0: nibble = bcd_q[3:0];
      2'd1: begin
        nibble = bcd_q[7:4];
        blank  = (BLANK_LEADING != 0) && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        nibble = bcd_q[11:8];
        blank  = (BLANK_LEADING != 0) && (bcd_q[11:8] == 4'd0);
      end
      default: blank = 1'b1;
    endcase
    if (blank) begin
      seg_next = SEG_OFF;
      an_next  = '1;
    end else begin
      seg_next = (SEG_ACTIVE_LOW != 0) ? ~bcd_to_seg(nibble) : bcd_to_seg(nibble);
      an_next  = ~(3'b001 << digit_idx);
    end
  end

  always_ff @(posedge clkin) begin
    if (!reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      seg_q       <= SEG_OFF;
      an_q        <= '1;
    end else begin
      if (refresh_cnt == REFRESH_LAST) begin
        refresh_cnt <= '0;
        digit_idx   <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 16'd1;
      end
      seg_q <= seg_next;
      an_q  <= an_next;
    end
  end

  assign bus.bcd  = bcd_q;
  assign bus.busy = busy_q;
  assign bus.seg  = seg_q;
  assign bus.an   = an_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Randomized scoreboard bench for count_display_driver with a decimal-arithmetic reference.
module tb_count_display_driver;
  import count_display_pkg::*;

  localparam int REF_A = 5;
  localparam int REF_B = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  count_display_driver_if bus_a ();
  count_display_driver_if bus_b ();

  count_display_driver #(.REFRESH_DIV(REF_A), .SEG_ACTIVE_LOW(1), .BLANK_LEADING(1)) dut_a (
    .clkin (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  count_display_driver #(.REFRESH_DIV(REF_B), .SEG_ACTIVE_LOW(0), .BLANK_LEADING(1)) dut_b (
    .clkin (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // ---------------- reference model ----------------
  logic [6:0] seg_lit [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  logic [11:0] last_exp;
  logic [11:0] prev_bcd = '0;
  logic        mon_en   = 1'b0;
  int          checks   = 0;
  int          errors   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Only visible changes of bcd are scored, so repeats of the same decimal are folded.
  task automatic push_exp(input int v);
    logic [11:0] e;
    e = to_bcd(v);
    if (e != last_exp) begin
      exp_q.push_back(e);
      last_exp = e;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && (bus_a.bcd !== prev_bcd)) begin
      if (exp_q.size() == 0) check("bcd_unexpected_change", 32'(bus_a.bcd), 32'(prev_bcd));
      else check("bcd_result", 32'(bus_a.bcd), 32'(exp_q.pop_front()));
    end
    prev_bcd = bus_a.bcd;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic vld, input logic [7:0] v);
    bus_a.value       = v;
    bus_a.value_valid = vld;
    bus_b.value       = v;
    bus_b.value_valid = vld;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus_a.busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("busy_timeout", 32'(bus_a.busy), 32'd0);
  endtask

  task automatic run_single(input int v);
    push_exp(v);
    drive(1'b1, 8'(v));
    @(negedge clk);
    drive(1'b0, 8'd0);
    wait_idle();
  endtask

  // Strobes at cycle offsets from the first; all later ones land while converting.
  task automatic burst(input int n, input int vals[3], input int offs[3]);
    int idx = 0;
    push_exp(vals[0]);
    if (n > 1) push_exp(vals[n-1]);
    for (int c = 0; c <= offs[n-1]; c++) begin
      if (idx < n && offs[idx] == c) begin
        drive(1'b1, 8'(vals[idx]));
        idx++;
      end else begin
        drive(1'b0, 8'd0);
      end
      @(negedge clk);
    end
    drive(1'b0, 8'd0);
    wait_idle();
  endtask

  task automatic check_display(input int which, input int v);
    int h, t, u, refd, run;
    logic blank_h, blank_t, inv, started, legal;
    logic [6:0] exp_seg, seg_s;
    logic [2:0] an_s, prev_an;
    logic seen [3];
    h = v / 100; t = (v / 10) % 10; u = v % 10;
    blank_h = (h == 0);
    blank_t = (h == 0) && (t == 0);
    refd = (which == 0) ? REF_A : REF_B;
    inv  = (which == 0);
    seen = '{1'b0, 1'b0, 1'b0};
    started = 1'b0; run = 0; prev_an = 3'b000;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6 * refd + 2; i++) begin
      @(negedge clk);
      if (which == 0) begin an_s = bus_a.an; seg_s = bus_a.seg; end
      else begin an_s = bus_b.an; seg_s = bus_b.seg; end
      legal = 1'b1;
      exp_seg = 7'h00;
      case (an_s)
        3'b110: begin exp_seg = seg_lit[u]; seen[0] = 1'b1; end
        3'b101: begin exp_seg = seg_lit[t]; seen[1] = 1'b1; legal = !blank_t; end
        3'b011: begin exp_seg = seg_lit[h]; seen[2] = 1'b1; legal = !blank_h; end
        3'b111: legal = blank_h;
        default: legal = 1'b0;
      endcase
      if (inv) exp_seg = ~exp_seg;
      check($sformatf("an_legal(an=%b,v=%0d)", an_s, v), 32'(legal), 32'd1);
      check($sformatf("seg(an=%b,v=%0d)", an_s, v), 32'(seg_s), 32'(exp_seg));
      if (!blank_h) begin
        if (i > 0 && an_s != prev_an) begin
          if (started) check("slot_period", 32'(run), 32'(refd));
          started = 1'b1;
          run = 1;
        end else begin
          run++;
        end
      end
      prev_an = an_s;
    end
    check("units_shown", 32'(seen[0]), 32'd1);
    check("tens_shown", 32'(seen[1]), 32'(!blank_t));
    check("hundreds_shown", 32'(seen[2]), 32'(!blank_h));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int vals[3];
    int offs[3];
    int n;
    logic busy_ok;
    drive(1'b0, 8'd0);
    last_exp = '0;

    // Reset held three cycles, then released with no strobe.
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bcd", 32'(bus_a.bcd), 32'h000);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_an", 32'(bus_a.an), 32'b111);
    check("rst_seg_low", 32'(bus_a.seg), 32'h7F);
    check("rst_seg_high", 32'(bus_b.seg), 32'h00);
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    check_display(0, 0);

    // 173: busy through edge k+8 samples, result visible after k+9.
    push_exp(173);
    drive(1'b1, 8'd173);
    @(negedge clk);
    drive(1'b0, 8'd0);
    busy_ok = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c <= 8 && bus_a.busy !== 1'b1) busy_ok = 1'b0;
    end
    check("t173_busy_window", 32'(busy_ok), 32'd1);
    check("t173_busy_clear", 32'(bus_a.busy), 32'd0);
    check("t173_bcd_latency", 32'(bus_a.bcd), 32'(to_bcd(173)));
    check_display(0, 173);

    // Extremes.
    run_single(255);
    check_display(0, 255);
    run_single(0);
    check_display(0, 0);

    // 42 at k, 99 at k+3, 7 at k+5: 99 is overwritten before it is converted.
    push_exp(42);
    push_exp(7);
    drive(1'b1, 8'd42);
    @(negedge clk);
    busy_ok = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      if (c == 3) drive(1'b1, 8'd99);
      else if (c == 5) drive(1'b1, 8'd7);
      else drive(1'b0, 8'd0);
      @(negedge clk);
      if (c <= 17 && bus_a.busy !== 1'b1) busy_ok = 1'b0;
      if (c == 9) check("chain_first_bcd", 32'(bus_a.bcd), 32'(to_bcd(42)));
      if (c == 19) check("chain_second_bcd", 32'(bus_a.bcd), 32'(to_bcd(7)));
    end
    check("chain_busy_continuous", 32'(busy_ok), 32'd1);
    wait_idle();
    check_display(0, 7);

    // Reset in the middle of converting 5.
    drive(1'b1, 8'd5);
    @(negedge clk);
    drive(1'b0, 8'd0);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(bus_a.busy), 32'd0);
    check("midrst_bcd", 32'(bus_a.bcd), 32'h000);
    check("midrst_an", 32'(bus_a.an), 32'b111);
    reset = 1'b1;
    last_exp = '0;
    @(negedge clk);
    mon_en = 1'b1;
    run_single(5);
    check_display(0, 5);

    // Randomized bursts, including a strobe on the completion edge.
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(1, 3);
      for (int j = 0; j < 3; j++) vals[j] = $urandom_range(0, 255);
      offs[0] = 0;
      offs[1] = (n == 2) ? $urandom_range(1, 9) : $urandom_range(1, 5);
      offs[2] = offs[1] + $urandom_range(1, 4);
      burst(n, vals, offs);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (it % 5 == 4) check_display(0, vals[n-1]);
    end

    // Active-high instance with fast refresh shows 1,0,0 with tens kept lit.
    run_single(100);
    check_display(1, 100);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
